// File: rtl/servisia_pkg.sv
// servisia_pkg: shared state encoding and port indices for the servisia SRAM arbiter.
package servisia_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_WRITE, ST_READ, ST_HOLD} sram_arb_state_e;
    localparam int PORT_CPU  = 0;
    localparam int PORT_LOAD = 1;
endpackage

// File: rtl/servisia_rr_arb2.sv
// servisia_rr_arb2: two-way round-robin grant; a tie goes to the port not served last.
module servisia_rr_arb2
    import servisia_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_upd,
    output logic       o_gnt
);
    logic r_last;
    assign o_gnt = &i_valid ? ~r_last : i_valid[PORT_LOAD];
    always_ff @(posedge i_clk) begin
        if (i_rst) r_last <= 1'b1;
        else if (i_upd) r_last <= o_gnt;
    end
endmodule

// File: rtl/servisia_sram_arb.sv
// servisia_sram_arb: arbitrates two requesters onto one async SRAM and sequences
// registered CS_N/WE_N/OE_N strobes with setup, pulse and hold cycles.
module servisia_sram_arb
    import servisia_pkg::*;
#(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 8,
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0]             req_we_i,
    input  logic [1:0][ADDR_W-1:0] req_addr_i,
    input  logic [1:0][DATA_W-1:0] req_wdata_i,
    output logic [1:0]             rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   sram_cs_n_o,
    output logic                   sram_we_n_o,
    output logic                   sram_oe_n_o,
    output logic [ADDR_W-1:0]      sram_addr_o,
    output logic [DATA_W-1:0]      sram_data_o,
    output logic                   sram_data_oe_o,
    input  logic [DATA_W-1:0]      sram_data_i
);
    localparam int CNT_MAX = WE_CYCLES > RD_CYCLES ? WE_CYCLES : RD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    sram_arb_state_e   r_state, w_state_n;
    logic [CW-1:0]     r_cnt, w_cnt_n;
    logic              r_port, r_we, w_gnt, w_hs, w_we;
    logic              r_cs_n, r_we_n, r_oe_n, r_data_oe;
    logic [1:0]        w_ready, r_rsp_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;

    servisia_rr_arb2 u_arb (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_valid (req_valid_i),
        .i_upd   (w_hs),
        .o_gnt   (w_gnt)
    );

    assign w_ready = (r_state == ST_IDLE && !rst_i) ? {w_gnt, ~w_gnt} & req_valid_i : 2'b00;
    assign w_hs    = |w_ready;
    assign w_we    = w_hs ? req_we_i[w_gnt] : r_we;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_IDLE:  w_state_n = w_hs ? ST_SETUP : ST_IDLE;
            ST_SETUP: begin
                w_state_n = r_we ? ST_WRITE : ST_READ;
                w_cnt_n   = r_we ? CW'(WE_CYCLES - 1) : CW'(RD_CYCLES - 1);
            end
            ST_WRITE, ST_READ: begin
                w_state_n = r_cnt == '0 ? ST_HOLD : r_state;
                w_cnt_n   = r_cnt == '0 ? r_cnt : r_cnt - 1'b1;
            end
            default:  w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Pad strobes are decoded from the next state so every pad sees a flop output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cs_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            r_cs_n      <= w_state_n == ST_IDLE;
            r_we_n      <= w_state_n != ST_WRITE;
            r_oe_n      <= w_state_n != ST_READ;
            r_data_oe   <= w_state_n != ST_IDLE && w_we;
            r_rsp_valid <= (w_state_n == ST_HOLD && !r_we) ? {r_port, ~r_port} : 2'b00;
            if (w_hs) begin
                r_port  <= w_gnt;
                r_we    <= req_we_i[w_gnt];
                r_addr  <= req_addr_i[w_gnt];
                r_wdata <= req_wdata_i[w_gnt];
            end
            if (r_state == ST_READ && r_cnt == '0) r_rdata <= sram_data_i;
        end
    end

    assign req_ready_o    = w_ready;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rdata;
    assign sram_cs_n_o    = r_cs_n;
    assign sram_we_n_o    = r_we_n;
    assign sram_oe_n_o    = r_oe_n;
    assign sram_addr_o    = r_addr;
    assign sram_data_o    = r_wdata;
    assign sram_data_oe_o = r_data_oe;
endmodule

// File: tb/tb_servisia_sram_arb.sv
// tb_servisia_sram_arb: directed vectors against a default instance and a
// WE_CYCLES=1 / RD_CYCLES=4 instance, each attached to a small SRAM model.
module tb_servisia_sram_arb;
    logic             clk = 1'b0, rst = 1'b1;
    logic [1:0]       req_valid[2], req_we[2], req_ready[2], rsp_valid[2];
    logic [1:0][20:0] req_addr[2];
    logic [1:0][7:0]  req_wdata[2];
    logic [7:0]       rsp_rdata[2], sram_wd[2], sram_rd[2];
    logic [20:0]      sram_addr[2];
    logic             cs_n[2], we_n[2], oe_n[2], data_oe[2];
    logic [7:0]       mem[2][0:4095];
    int               n_vec = 0, n_err = 0, overlap = 0;
    int               cs_lo, we_lo, oe_lo, rv_k, uns, ng, nr, ns, errs, gaps;
    int               g_port[8], g_cyc[8], hs[16];
    logic [1:0]       rv_vec, r_vec[8];
    logic [7:0]       rd, r_dat[8];

    always #5 clk = ~clk;

    servisia_sram_arb u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .sram_cs_n_o(cs_n[0]),
        .sram_we_n_o(we_n[0]), .sram_oe_n_o(oe_n[0]), .sram_addr_o(sram_addr[0]),
        .sram_data_o(sram_wd[0]), .sram_data_oe_o(data_oe[0]), .sram_data_i(sram_rd[0])
    );

    servisia_sram_arb #(.WE_CYCLES(1), .RD_CYCLES(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .sram_cs_n_o(cs_n[1]),
        .sram_we_n_o(we_n[1]), .sram_oe_n_o(oe_n[1]), .sram_addr_o(sram_addr[1]),
        .sram_data_o(sram_wd[1]), .sram_data_oe_o(data_oe[1]), .sram_data_i(sram_rd[1])
    );

    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (!cs_n[d] && !we_n[d] && data_oe[d]) mem[d][sram_addr[d][11:0]] <= sram_wd[d];
    assign sram_rd[0] = (!cs_n[0] && !oe_n[0]) ? mem[0][sram_addr[0][11:0]] : 8'hEE;
    assign sram_rd[1] = (!cs_n[1] && !oe_n[1]) ? mem[1][sram_addr[1][11:0]] : 8'hEE;
    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            if (!oe_n[d] && data_oe[d]) overlap <= overlap + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one request at a negedge and profiles the next 9 cycles of pad activity.
    task automatic xact(input int d, input int p, input logic we, input logic [20:0] a,
                        input logic [7:0] wd);
        int t;
        t = 0;
        req_valid[d][p] = 1'b1; req_we[d][p] = we; req_addr[d][p] = a; req_wdata[d][p] = wd;
        #1;
        while (!req_ready[d][p] && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 20) chk("accept_timeout", t, 0);
        @(negedge clk);
        req_valid[d][p] = 1'b0;
        cs_lo = 0; we_lo = 0; oe_lo = 0; rv_k = 0; uns = 0; rv_vec = 2'b00; rd = 8'h00;
        for (int k = 1; k <= 9; k++) begin
            cs_lo += int'(!cs_n[d]); we_lo += int'(!we_n[d]); oe_lo += int'(!oe_n[d]);
            if (!cs_n[d] && (sram_addr[d] !== a || (we && (sram_wd[d] !== wd || !data_oe[d])))) uns++;
            if (rsp_valid[d] != 2'b00) begin
                rv_k = k; rv_vec = rsp_valid[d]; rd = rsp_rdata[d];
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int j = 0; j < 4096; j++) begin
            mem[0][j] <= 8'h00; mem[1][j] <= 8'h00;
        end
        mem[0][12'h020] <= 8'h11;
        mem[0][12'h030] <= 8'h22;
        req_valid[0] = 2'b11; req_valid[1] = 2'b00; req_we[0] = 2'b00; req_we[1] = 2'b00;
        req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cs_n", cs_n[0], 1); chk("rst_we_n", we_n[0], 1); chk("rst_oe_n", oe_n[0], 1);
        chk("rst_addr", sram_addr[0], 0); chk("rst_data", sram_wd[0], 0);
        chk("rst_data_oe", data_oe[0], 0); chk("rst_ready", req_ready[0], 0);
        chk("rst_rsp_valid", rsp_valid[0], 0); chk("rst_rdata", rsp_rdata[0], 0);
        req_valid[0] = 2'b00; rst = 1'b0;
        @(negedge clk);

        xact(0, 0, 1'b1, 21'h00010, 8'hA5);
        chk("wr_cs_lo", cs_lo, 4); chk("wr_we_lo", we_lo, 2); chk("wr_oe_lo", oe_lo, 0);
        chk("wr_stable", uns, 0); chk("wr_no_rsp", rv_k, 0); chk("wr_mem", mem[0][12'h010], 8'hA5);

        xact(0, 0, 1'b0, 21'h00010, 8'h00);
        chk("rd_cs_lo", cs_lo, 4); chk("rd_oe_lo", oe_lo, 2); chk("rd_we_lo", we_lo, 0);
        chk("rd_latency", rv_k, 4); chk("rd_port", rv_vec, 2'b01); chk("rd_data", rd, 8'hA5);

        req_valid[0][0] = 1'b1; req_we[0][0] = 1'b0; req_addr[0][0] = 21'h00020;
        #1;
        chk("rr_ready", req_ready[0], 2'b01);
        @(negedge clk); req_valid[0][0] = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        chk("mr_cs_n", cs_n[0], 1); chk("mr_we_n", we_n[0], 1); chk("mr_oe_n", oe_n[0], 1);
        chk("mr_data_oe", data_oe[0], 0); chk("mr_rsp_valid", rsp_valid[0], 0);
        chk("mr_rdata", rsp_rdata[0], 0);

        rst = 1'b0; req_we[0] = 2'b00;
        req_addr[0][0] = 21'h00020; req_addr[0][1] = 21'h00030; req_valid[0] = 2'b11;
        ng = 0; nr = 0;
        for (int c = 0; c < 26; c++) begin
            if (ng == 4) req_valid[0] = 2'b00;
            #1;
            if (req_ready[0] != 2'b00 && ng < 8) begin
                g_port[ng] = int'(req_ready[0][1]); g_cyc[ng] = c; ng++;
            end
            if (rsp_valid[0] != 2'b00 && nr < 8) begin
                r_vec[nr] = rsp_valid[0]; r_dat[nr] = rsp_rdata[0]; nr++;
            end
            @(negedge clk);
        end
        chk("alt_grants", ng, 4); chk("alt_rsps", nr, 4);
        for (int i = 0; i < 4; i++) begin
            chk("alt_gnt_port", g_port[i], i % 2);
            chk("alt_rsp_port", r_vec[i], (i % 2 == 1) ? 2'b10 : 2'b01);
            chk("alt_rsp_data", r_dat[i], (i % 2 == 1) ? 8'h22 : 8'h11);
            if (i > 0) chk("alt_period", g_cyc[i] - g_cyc[i-1], 5);
        end

        ns = 0;
        req_we[0][1] = 1'b1; req_addr[0][1] = 21'h00100; req_wdata[0][1] = 8'h00; req_valid[0][1] = 1'b1;
        for (int c = 0; c < 90; c++) begin
            #1;
            if (req_ready[0][1]) begin
                if (ns < 16) hs[ns] = c;
                ns++;
            end
            @(negedge clk);
            if (ns >= 16) req_valid[0][1] = 1'b0;
            else begin
                req_addr[0][1] = 21'(32'h100 + ns); req_wdata[0][1] = 8'(ns);
            end
        end
        gaps = 0; errs = 0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0 && hs[j] - hs[j-1] == 5) gaps++;
            if (mem[0][12'h100 + j] !== 8'(j)) errs++;
        end
        chk("ld_count", ns, 16); chk("ld_b2b_gaps", gaps, 15); chk("ld_mem_errs", errs, 0);
        xact(0, 1, 1'b0, 21'h00103, 8'h00);
        chk("ld_rb3_port", rv_vec, 2'b10); chk("ld_rb3_data", rd, 8'h03);
        xact(0, 1, 1'b0, 21'h0010F, 8'h00);
        chk("ld_rbF_data", rd, 8'h0F);

        xact(1, 0, 1'b1, 21'h00040, 8'h3C);
        chk("p_wr_we_lo", we_lo, 1); chk("p_wr_cs_lo", cs_lo, 3); chk("p_wr_mem", mem[1][12'h040], 8'h3C);
        xact(1, 0, 1'b0, 21'h00040, 8'h00);
        chk("p_rd_oe_lo", oe_lo, 4); chk("p_rd_cs_lo", cs_lo, 6);
        chk("p_rd_latency", rv_k, 6); chk("p_rd_data", rd, 8'h3C);

        chk("oe_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
